uart_tx_8x: RTL

- UART transmitter for the fpga_core serial link; the transmit counterpart to the 8x-oversampling receiver on rxd.
- Serialises bytes from an AXI-Stream-style sink onto txd: 8N1 by default, optional even parity.
- Bit timing uses the same prescale convention as the rest of the link. One bit period is prescale*8 clk cycles, so the same parameter value gives matching baud on both directions.

---
 rtl/uart_tx_8x.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_8x.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_8x
// Brief    : UART transmitter, 8N1 by default; bit period is PRESCALE*8 clk.
//            Define UART_TX_PARITY_EN to insert an even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_8x #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 92
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  txd,
    output logic                  busy
);

    localparam int C_BP    = PRESCALE * 8;
    localparam int C_CNT_W = $clog2(C_BP);
    localparam int C_BIT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [C_CNT_W-1:0] C_CNT_RELOAD = C_CNT_W'(C_BP - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE    = C_CNT_W'(1);
    localparam logic [C_BIT_W-1:0] C_BIT_LAST   = C_BIT_W'(DATA_WIDTH);
    localparam logic [C_BIT_W-1:0] C_BIT_ONE    = C_BIT_W'(1);

    localparam logic [2:0] C_IDLE   = 3'd0;
    localparam logic [2:0] C_START  = 3'd1;
    localparam logic [2:0] C_DATA   = 3'd2;
    localparam logic [2:0] C_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] C_PARITY = 3'd4;
`endif

    logic [2:0]            state_q, state_d;
    logic [C_CNT_W-1:0]    cnt_q,   cnt_d;
    logic [C_BIT_W-1:0]    bit_q,   bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  txd_q,   txd_d;
    logic                  busy_q,  busy_d;
    logic                  tready_q, tready_d;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    logic w_handshake;
    logic w_tick;

    assign w_handshake = s_axis_tvalid && tready_q;
    assign w_tick      = (cnt_q == '0);

    // ------------------------------------------------------------------
    // State register (all outputs are registered here as well)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= C_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            tready_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
            tready_q <= tready_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q != C_IDLE) begin
            cnt_d = w_tick ? C_CNT_RELOAD : (cnt_q - C_CNT_ONE);
        end

        case (state_q)
            C_IDLE: begin
                if (w_handshake) begin
                    state_d = C_START;
                    cnt_d   = C_CNT_RELOAD;
                    bit_d   = '0;
                    shift_d = s_axis_tdata;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^s_axis_tdata;
`endif
                end
            end
            C_START: begin
                if (w_tick) begin
                    state_d = C_DATA;
                    bit_d   = C_BIT_ONE;
                    shift_d = shift_q >> 1;
                end
            end
            C_DATA: begin
                // bit_q counts bits already put on the line
                if (w_tick) begin
                    if (bit_q == C_BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = C_PARITY;
`else
                        state_d = C_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + C_BIT_ONE;
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            C_PARITY: begin
                if (w_tick) begin
                    state_d = C_STOP;
                end
            end
`endif
            C_STOP: begin
                if (w_tick) begin
                    state_d = C_IDLE;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            default: begin
                state_d = C_IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode; txd only moves on a handshake or a bit boundary
    // ------------------------------------------------------------------
    always_comb begin
        txd_d    = txd_q;
        busy_d   = busy_q;
        tready_d = tready_q;
        if (state_q == C_IDLE) begin
            txd_d    = !w_handshake;
            busy_d   = w_handshake;
            tready_d = !w_handshake;
        end else if (w_tick) begin
            case (state_d)
                C_DATA:   txd_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
                C_PARITY: txd_d = parity_q;
`endif
                C_STOP:   txd_d = 1'b1;
                C_IDLE: begin
                    txd_d    = 1'b1;
                    busy_d   = 1'b0;
                    tready_d = 1'b1;
                end
                default:  txd_d = txd_q;
            endcase
        end
    end

    assign txd           = txd_q;
    assign busy          = busy_q;
    assign s_axis_tready = tready_q;

endmodule
`default_nettype wire
